// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: instruction field
// constants, ALU control encodings and the sequencer state enum.
package alu_issue_seq_pkg;

  localparam int ALU_CTRL_W = 3;

  typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;

  // Opcode field values
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;

  // Funct field values for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control encodings
  localparam alu_ctrl_t OP_AND = 3'b000;
  localparam alu_ctrl_t OP_OR  = 3'b001;
  localparam alu_ctrl_t OP_ADD = 3'b010;
  localparam alu_ctrl_t OP_SUB = 3'b110;
  localparam alu_ctrl_t OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_seq_decoder.sv
// Combinational instruction decoder: opcode/funct -> ALU control + illegal.
module alu_issue_decoder
  import alu_issue_seq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_ctrl_t  control,
  output logic       illegal
);

  // Decode table; anything not listed is flagged illegal with control 0.
  always_comb begin
    control = '0;
    illegal = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD: begin control = OP_ADD; illegal = 1'b0; end
          FN_SUB: begin control = OP_SUB; illegal = 1'b0; end
          FN_AND: begin control = OP_AND; illegal = 1'b0; end
          FN_OR:  begin control = OP_OR;  illegal = 1'b0; end
          FN_SLT: begin control = OP_SLT; illegal = 1'b0; end
          default: begin control = '0; illegal = 1'b1; end
        endcase
      end
      OPC_LW, OPC_SW, OPC_ADDI: begin control = OP_ADD; illegal = 1'b0; end
      OPC_BEQ:                  begin control = OP_SUB; illegal = 1'b0; end
      default:                  begin control = '0;     illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/alu_issue_seq.sv
// ALU issue sequencer: accepts a decoded instruction request, issues it to
// an external combinational ALU for one cycle and holds the response until
// it is consumed. Optional feature: define ALU_ISSUE_SEQ_ZERO_EN to drive
// o_zero from the captured result; otherwise o_zero is tied low.
//
// Handshakes: a request transfers on a rising edge where i_valid and o_ready
// are both high; a response transfers on a rising edge where o_valid and
// i_ready are both high. Once raised, o_valid and the response fields hold
// until that transfer; i_valid/i_ready outside their windows are ignored.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int DATA_WIDTH_P  = 32,
  parameter int CNTRL_WIDTH_P = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [5:0]               i_opcode,
  input  logic [5:0]               i_funct,
  input  logic [DATA_WIDTH_P-1:0]  i_a,
  input  logic [DATA_WIDTH_P-1:0]  i_b,
  output logic [CNTRL_WIDTH_P-1:0] o_alu_control,
  output logic [DATA_WIDTH_P-1:0]  o_alu_a,
  output logic [DATA_WIDTH_P-1:0]  o_alu_b,
  input  logic [DATA_WIDTH_P-1:0]  i_alu_result,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_WIDTH_P-1:0]  o_result,
  output logic                     o_zero,
  output logic                     o_illegal,
  output state_t                   dbg_state
);

  state_t    state;
  alu_ctrl_t dec_control;
  logic      dec_illegal;

  alu_issue_decoder u_decoder (
    .opcode  (i_opcode),
    .funct   (i_funct),
    .control (dec_control),
    .illegal (dec_illegal)
  );

  // Sequencer: IDLE accepts, EXEC issues to the ALU, RESP holds the answer.
  // Illegal requests skip EXEC and leave the ALU operand registers untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      o_alu_control <= '0;
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_result      <= '0;
      o_zero        <= 1'b0;
      o_illegal     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            o_illegal <= dec_illegal;
            if (dec_illegal) begin
              o_result <= '0;
              o_zero   <= 1'b0;
              state    <= RESP;
            end else begin
              o_alu_control <= CNTRL_WIDTH_P'(dec_control);
              o_alu_a       <= i_a;
              o_alu_b       <= i_b;
              state         <= EXEC;
            end
          end
        end
        EXEC: begin
          o_result <= i_alu_result;
`ifdef ALU_ISSUE_SEQ_ZERO_EN
          o_zero   <= (i_alu_result == '0);
`else
          o_zero   <= 1'b0;
`endif
          state    <= RESP;
        end
        RESP: begin
          if (i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags are pure decodes of the state register.
  assign o_ready   = (state == IDLE);
  assign o_valid   = (state == RESP);
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq with an external reference ALU.
module tb_alu_issue_seq;
  import alu_issue_seq_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         i_valid, i_ready;
  logic         o_ready, o_valid, o_zero, o_illegal;
  logic [5:0]   i_opcode, i_funct;
  logic [W-1:0] i_a, i_b, o_alu_a, o_alu_b, alu_result, o_result;
  logic [2:0]   o_alu_control;
  state_t       dbg_state;

  alu_issue_seq #(.DATA_WIDTH_P(W), .CNTRL_WIDTH_P(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_opcode      (i_opcode),
    .i_funct       (i_funct),
    .i_a           (i_a),
    .i_b           (i_b),
    .o_alu_control (o_alu_control),
    .o_alu_a       (o_alu_a),
    .o_alu_b       (o_alu_b),
    .i_alu_result  (alu_result),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_result      (o_result),
    .o_zero        (o_zero),
    .o_illegal     (o_illegal),
    .dbg_state     (dbg_state)
  );

  // External ALU driven by the sequencer's issue outputs
  always_comb begin
    alu_result = '0;
    case (o_alu_control)
      3'b010: alu_result = o_alu_a + o_alu_b;
      3'b110: alu_result = o_alu_a - o_alu_b;
      3'b000: alu_result = o_alu_a & o_alu_b;
      3'b001: alu_result = o_alu_a | o_alu_b;
      3'b111: alu_result = ($signed(o_alu_a) < $signed(o_alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit           illegal;
    logic [2:0]   ctrl;
    logic [W-1:0] result;
  } exp_t;

  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    m.illegal = 1'b0;
    m.ctrl    = 3'b000;
    m.result  = '0;
    if (op == 6'h00) begin
      if (fn == 6'h20)      begin m.ctrl = 3'b010; m.result = a + b; end
      else if (fn == 6'h22) begin m.ctrl = 3'b110; m.result = a - b; end
      else if (fn == 6'h24) begin m.ctrl = 3'b000; m.result = a & b; end
      else if (fn == 6'h25) begin m.ctrl = 3'b001; m.result = a | b; end
      else if (fn == 6'h2a) begin m.ctrl = 3'b111; m.result = {31'd0, $signed(a) < $signed(b)}; end
      else m.illegal = 1'b1;
    end else if (op == 6'h23 || op == 6'h2b || op == 6'h08) begin
      m.ctrl = 3'b010; m.result = a + b;
    end else if (op == 6'h04) begin
      m.ctrl = 3'b110; m.result = a - b;
    end else begin
      m.illegal = 1'b1;
    end
    return m;
  endfunction

  function automatic logic exp_zero(input exp_t m);
`ifdef ALU_ISSUE_SEQ_ZERO_EN
    return !m.illegal && (m.result == '0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [2:0]   last_ctrl;
  logic [W-1:0] last_a, last_b;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},   o_valid, 0);
    check({tag, "_result"},  o_result, 0);
    check({tag, "_zero"},    o_zero, 0);
    check({tag, "_illegal"}, o_illegal, 0);
    check({tag, "_ctrl"},    o_alu_control, 0);
    check({tag, "_a"},       o_alu_a, 0);
    check({tag, "_b"},       o_alu_b, 0);
  endtask

  // ---------------- driver ----------------
  // One full transaction: accept, latency, response contents, optional
  // back-pressure of 'hold' cycles (with ignored requests if poke), consume.
  task automatic send(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input int hold, input bit poke);
    exp_t         m;
    int           lat;
    logic [W-1:0] er;
    m = model(op, fn, a, b);
    // i_ready with no response pending must not disturb anything
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check({tag, "_idle_ready"}, o_ready, 1);
    check({tag, "_idle_valid"}, o_valid, 0);
    i_valid = 1'b1; i_opcode = op; i_funct = fn; i_a = a; i_b = b;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    exp_q.push_back(m.result);
    if (!m.illegal) begin
      last_ctrl = m.ctrl; last_a = a; last_b = b;
    end
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, m.illegal ? 1 : 2);
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_ready_low"}, o_ready, 0);
    check({tag, "_alu_ctrl"}, o_alu_control, last_ctrl);
    check({tag, "_alu_a"}, o_alu_a, last_a);
    check({tag, "_alu_b"}, o_alu_b, last_b);
    er = exp_q.pop_front();
    check({tag, "_result"}, o_result, er);
    check({tag, "_illegal"}, o_illegal, m.illegal);
    check({tag, "_zero"}, o_zero, exp_zero(m));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        i_valid = 1'b1; i_opcode = 6'h00; i_funct = 6'h22;
        i_a = $urandom; i_b = $urandom;
      end
      @(negedge clk);
      check({tag, "_hold_valid"}, o_valid, 1);
      check({tag, "_hold_result"}, o_result, er);
      check({tag, "_hold_ready"}, o_ready, 0);
      check({tag, "_hold_alu_a"}, o_alu_a, last_a);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    check({tag, "_done_valid"}, o_valid, 0);
    check({tag, "_done_ready"}, o_ready, 1);
  endtask

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [5:0] op_tab [8];
  logic [5:0] fn_tab [6];

  initial begin
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h3f};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h21};
    reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_opcode = '0; i_funct = '0; i_a = '0; i_b = '0;
    last_ctrl = '0; last_a = '0; last_b = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("rst_held");
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("rst_rel");
    check("rst_ready", o_ready, 1);

    send("add_5_7",    6'h00, 6'h20, 32'd5, 32'd7, 0, 0);
    send("slt_3_9",    6'h00, 6'h2a, 32'd3, 32'd9, 0, 0);
    send("slt_9_3",    6'h00, 6'h2a, 32'd9, 32'd3, 0, 0);
    send("beq_eq",     6'h04, 6'h00, 32'h1234, 32'h1234, 0, 0);
    send("illegal_op", 6'h3f, 6'h20, 32'hdead, 32'hbeef, 0, 0);
    send("illegal_fn", 6'h00, 6'h03, 32'h11, 32'h22, 1, 0);
    send("hold5",      6'h00, 6'h22, 32'd100, 32'd1, 5, 1);
    send("slt_neg",    6'h00, 6'h2a, 32'hffff_fff0, 32'd2, 0, 0);

    // Reset in EXEC discards the in-flight request
    @(negedge clk);
    i_valid = 1'b1; i_opcode = 6'h00; i_funct = 6'h20; i_a = 32'd40; i_b = 32'd2;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check("rexec_in_exec_valid", o_valid, 0);
    check("rexec_in_exec_ready", o_ready, 0);
    reset = 1'b1;
    #1;
    check_zero_outputs("rexec_async");
    @(negedge clk);
    reset = 1'b0;
    last_ctrl = '0; last_a = '0; last_b = '0;
    @(negedge clk);
    check_zero_outputs("rexec_after");
    check("rexec_ready", o_ready, 1);
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rexec_no_resp", o_valid, 0);
    end
    i_ready = 1'b0;

    // Randomized mix of legal and illegal requests
    for (int k = 0; k < 30; k++) begin
      logic [5:0]   op, fn;
      logic [W-1:0] a, b;
      op = op_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fn_tab[$urandom_range(0, 5)];
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      send("rand", op, fn, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
